// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: opcodes, format
// classes, the NOP word and the output-slot state encoding.
package imm_encoder_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0 -- substituted for unrecognised opcodes
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_e;

    // Map an opcode onto its instruction format class
    function automatic fmt_e opcode_fmt(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_REG:                    f = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:  f = FMT_I;
            OP_STORE:                  f = FMT_S;
            OP_BRANCH:                 f = FMT_B;
            OP_LUI, OP_AUIPC:          f = FMT_U;
            OP_JAL:                    f = FMT_J;
            default:                   f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational core: classifies the opcode, scatters the immediate into
// the format's bit positions and flags out-of-range or misaligned values.
// An erroneous immediate is still packed from its truncated low bits.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_instr,
    output logic        o_err
);

    fmt_e w_fmt;
    logic w_fit12;
    logic w_fit13;
    logic w_fit21;

    assign w_fmt = opcode_fmt(i_opcode);

    // A value fits N-bit signed when every bit above N-1 copies bit N-1
    assign w_fit12 = (i_imm[31:11] == {21{i_imm[11]}});
    assign w_fit13 = (i_imm[31:12] == {20{i_imm[12]}});
    assign w_fit21 = (i_imm[31:20] == {12{i_imm[20]}});

    // Pack the word for the decoded format and evaluate the immediate rule
    always_comb begin
        o_instr = NOP_WORD;
        o_err   = 1'b1;
        case (w_fmt)
            FMT_R: begin
                o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
                o_err   = 1'b0;
            end
            FMT_I: begin
                o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_err   = !w_fit12;
            end
            FMT_S: begin
                o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_err   = !w_fit12;
            end
            FMT_B: begin
                o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], i_opcode};
                o_err   = !w_fit13 || i_imm[0];
            end
            FMT_U: begin
                o_instr = {i_imm[31:12], i_rd, i_opcode};
                o_err   = (i_imm[11:0] != 12'h000);
            end
            FMT_J: begin
                o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_err   = !w_fit21 || i_imm[0];
            end
            default: begin
                o_instr = NOP_WORD;
                o_err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// RV32I instruction encoder with a single registered output slot, a
// wrapping sequential address counter and a saturating error counter.
//
// Handshake: a bundle transfers on a rising edge where in_valid & in_ready;
// a result transfers on a rising edge where out_valid & out_ready. While
// out_valid is high and out_ready low, out_instr/out_addr/out_err hold.
// in_ready = slot empty | out_ready, so a drain and a refill can share an
// edge with no bubble. clear overrides both transfers in its cycle.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 256
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [7:0]  err_cnt,
    output slot_state_e dbg_state
);

    localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    slot_state_e      r_state;
    slot_state_e      w_next_state;
    logic [31:0]      r_instr;
    logic             r_err;
    logic [31:0]      r_addr;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_err_cnt;
    logic [31:0]      w_instr;
    logic             w_err;
    logic             w_accept;
    logic             w_out_hs;

    imm_pack u_pack (
        .i_opcode (opcode),
        .i_rd     (rd),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .i_funct3 (funct3),
        .i_funct7 (funct7),
        .i_imm    (imm),
        .o_instr  (w_instr),
        .o_err    (w_err)
    );

    assign w_accept = in_valid & in_ready;
    assign w_out_hs = out_valid & out_ready;

    // Slot state register; clear empties the slot and drops any held word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
        end else if (clear) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next slot state: fill on accept, empty on a drain with no refill
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SLOT_EMPTY: if (w_accept) w_next_state = SLOT_FULL;
            SLOT_FULL:  if (out_ready && !w_accept) w_next_state = SLOT_EMPTY;
            default:    w_next_state = SLOT_EMPTY;
        endcase
    end

    // Handshake outputs derived from the slot state
    always_comb begin
        in_ready  = (r_state == SLOT_EMPTY) || out_ready;
        out_valid = (r_state == SLOT_FULL);
    end

    // Capture the packed word and its error flag on every accepted bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= 32'h0000_0000;
            r_err   <= 1'b0;
        end else if (!clear && w_accept) begin
            r_instr <= w_instr;
            r_err   <= w_err;
        end
    end

    // Address and error bookkeeping advance once per delivered word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= BASE_ADDR;
            r_idx     <= '0;
            r_err_cnt <= 8'd0;
        end else if (clear) begin
            r_addr    <= BASE_ADDR;
            r_idx     <= '0;
            r_err_cnt <= 8'd0;
        end else if (w_out_hs) begin
            if (r_idx == LAST_IDX) begin
                r_addr <= BASE_ADDR;
                r_idx  <= '0;
            end else begin
                r_addr <= r_addr + 32'd4;
                r_idx  <= r_idx + 1'b1;
            end
            if (r_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign out_instr = r_instr;
    assign out_err   = r_err;
    assign out_addr  = r_addr;
    assign err_cnt   = r_err_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vector table with exact words, stall,
// wrap, saturation, clear and reset sequences, then randomized traffic
// checked by decoding each produced word back into fields.
module tb_imm_encoder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 256;
  localparam int F_R = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5, F_BAD = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_cnt;
  imm_encoder_pkg::slot_state_e dbg_state;

  imm_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / timeout ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before 500us");
    $fatal(1, "timeout");
  end

  // ---------------- types / scoreboard ----------------
  typedef struct {
    int          fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_t;
    logic        err;
    logic        has_word;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] word;
    logic        err;
  } vec_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   m_idx = 0;
  int   m_err_cnt = 0;
  logic rand_ready = 1'b0;
  exp_t mon_e;
  exp_t mon_d;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: format, legality and the immediate value the word must carry
  function automatic exp_t ref_model(input logic [6:0] op, input logic [4:0] a_rd,
                                     input logic [4:0] a_rs1, input logic [4:0] a_rs2,
                                     input logic [2:0] a_f3, input logic [6:0] a_f7,
                                     input logic [31:0] a_imm);
    exp_t   e;
    longint si;
    longint v;
    si = longint'($signed(a_imm));
    e.fmt = F_BAD; e.op = op; e.rd = '0; e.rs1 = '0; e.rs2 = '0;
    e.f3 = '0; e.f7 = '0; e.imm_t = '0; e.err = 1'b1; e.has_word = 1'b0; e.word = '0;
    case (op)
      7'b0110011: begin
        e.fmt = F_R; e.rd = a_rd; e.rs1 = a_rs1; e.rs2 = a_rs2; e.f3 = a_f3; e.f7 = a_f7;
        e.err = 1'b0;
      end
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011: begin
        if (op == 7'b0100011) begin
          e.fmt = F_S; e.rs2 = a_rs2;
        end else begin
          e.fmt = F_I; e.rd = a_rd;
        end
        e.rs1 = a_rs1; e.f3 = a_f3;
        e.err = (si < -2048) || (si > 2047);
        v = longint'(a_imm % 32'd4096);
        if (v >= 2048) v = v - 4096;
        e.imm_t = 32'(v);
      end
      7'b1100011: begin
        e.fmt = F_B; e.rs1 = a_rs1; e.rs2 = a_rs2; e.f3 = a_f3;
        e.err = (si < -4096) || (si > 4095) || ((a_imm % 32'd2) != 0);
        v = longint'(a_imm % 32'd8192);
        v = v - (v % 2);
        if (v >= 4096) v = v - 8192;
        e.imm_t = 32'(v);
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = F_U; e.rd = a_rd;
        e.err = (a_imm % 32'd4096) != 0;
        e.imm_t = a_imm - (a_imm % 32'd4096);
      end
      7'b1101111: begin
        e.fmt = F_J; e.rd = a_rd;
        e.err = (si < -1048576) || (si > 1048575) || ((a_imm % 32'd2) != 0);
        v = longint'(a_imm % 32'd2097152);
        v = v - (v % 2);
        if (v >= 1048576) v = v - 2097152;
        e.imm_t = 32'(v);
      end
      default: begin
        e.has_word = 1'b1; e.word = 32'h0000_0013;
      end
    endcase
    return e;
  endfunction

  // Standard RV32I decode of a word, as the instruction fetch side sees it
  function automatic exp_t decode(input logic [31:0] w, input int fmt);
    exp_t   d;
    longint v;
    d.fmt = fmt; d.op = w[6:0]; d.rd = '0; d.rs1 = '0; d.rs2 = '0;
    d.f3 = '0; d.f7 = '0; d.imm_t = '0; d.err = 1'b0; d.has_word = 1'b0; d.word = w;
    case (fmt)
      F_R: begin
        d.rd = w[11:7]; d.f3 = w[14:12]; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.f7 = w[31:25];
      end
      F_I: begin
        d.rd = w[11:7]; d.f3 = w[14:12]; d.rs1 = w[19:15];
        v = longint'(w[31:20]);
        if (v >= 2048) v = v - 4096;
        d.imm_t = 32'(v);
      end
      F_S: begin
        d.f3 = w[14:12]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
        v = longint'({w[31:25], w[11:7]});
        if (v >= 2048) v = v - 4096;
        d.imm_t = 32'(v);
      end
      F_B: begin
        d.f3 = w[14:12]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
        v = longint'({w[31], w[7], w[30:25], w[11:8], 1'b0});
        if (v >= 4096) v = v - 8192;
        d.imm_t = 32'(v);
      end
      F_U: begin
        d.rd = w[11:7];
        d.imm_t = {w[31:12], 12'h000};
      end
      F_J: begin
        d.rd = w[11:7];
        v = longint'({w[31], w[19:12], w[20], w[30:21], 1'b0});
        if (v >= 1048576) v = v - 2097152;
        d.imm_t = 32'(v);
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] pk(input exp_t x);
    return {x.op, x.rd, x.rs1, x.rs2, x.f3, x.f7};
  endfunction

  // Scoreboard: checks every output handshake against the queue head
  always @(negedge clk) begin
    if (!rst_n || clear) begin
      exp_q.delete();
      m_idx = 0;
      m_err_cnt = 0;
    end else if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_output: got word %h, expected no output", out_instr);
      end else begin
        mon_e = exp_q.pop_front();
        mon_d = decode(out_instr, mon_e.fmt);
        if (mon_e.has_word) check32("word", out_instr, mon_e.word);
        if (mon_e.fmt != F_BAD) check32("fields", pk(mon_d), pk(mon_e));
        if (mon_e.fmt != F_BAD && mon_e.fmt != F_R) check32("imm", mon_d.imm_t, mon_e.imm_t);
        check32("err", 32'(out_err), 32'(mon_e.err));
        check32("addr", out_addr, BASE + 32'(m_idx * 4));
        check32("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
        m_idx = (m_idx + 1) % DEPTH;
        if (mon_e.err && m_err_cnt != 255) m_err_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] a_rd, input logic [4:0] a_rs1,
                      input logic [4:0] a_rs2, input logic [2:0] a_f3, input logic [6:0] a_f7,
                      input logic [31:0] a_imm, input logic use_tbl, input logic [31:0] t_word,
                      input logic t_err, output int waits);
    exp_t e;
    bit   acc;
    int   n;
    acc = 1'b0;
    n = 0;
    e = ref_model(op, a_rd, a_rs1, a_rs2, a_f3, a_f7, a_imm);
    if (use_tbl) begin
      e.has_word = 1'b1; e.word = t_word; e.err = t_err;
    end
    opcode = op; rd = a_rd; rs1 = a_rs1; rs2 = a_rs2;
    funct3 = a_f3; funct7 = a_f7; imm = a_imm;
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        acc = 1'b1;
      end else begin
        n++;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!acc) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected accept", n);
    end
    waits = n;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain_timeout: got %0d pending words, expected 0", exp_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t        vecs[17];
  logic [6:0]  ops[10];
  logic [31:0] bnd[10];

  initial begin
    int w;
    int total;
    logic [31:0] r;

    vecs[0]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,         32'h0050_0093, 1'b0};
    vecs[1]  = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0};
    vecs[2]  = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,         32'h0000_0163, 1'b1};
    vecs[3]  = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    vecs[4]  = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 32'h1234_52B7, 1'b1};
    vecs[5]  = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0};
    vecs[6]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,      32'h8000_0093, 1'b1};
    vecs[7]  = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 1'b0};
    vecs[8]  = '{7'h7F, 5'd1, 5'd2, 5'd3, 3'd1, 7'h00, 32'd7,         32'h0000_0013, 1'b1};
    vecs[9]  = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,         32'h0020_81B3, 1'b0};
    vecs[10] = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,         32'h4020_81B3, 1'b0};
    vecs[11] = '{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,         32'h0020_A423, 1'b0};
    vecs[12] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0801, 32'h0010_00EF, 1'b1};
    vecs[13] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, 32'h8000_00EF, 1'b1};
    vecs[14] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0FFE, 32'h7E00_0FE3, 1'b0};
    vecs[15] = '{7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, 32'hFFFF_FFFC, 32'hFFC1_2283, 1'b0};
    vecs[16] = '{7'h17, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F000, 32'hFFFF_F117, 1'b0};

    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    bnd = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd4094,
            32'd4096, 32'hFFFF_F000, 32'h000F_FFFE, 32'h0010_0000, 32'hFFF0_0000};

    // reset
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check32("rst_out_valid", 32'(out_valid), 32'd0);
    check32("rst_out_instr", out_instr, 32'h0);
    check32("rst_out_addr", out_addr, BASE);
    check32("rst_out_err", 32'(out_err), 32'd0);
    check32("rst_err_cnt", 32'(err_cnt), 32'd0);
    check32("rst_in_ready", 32'(in_ready), 32'd1);
    check32("rst_state", 32'(dbg_state), 32'(imm_encoder_pkg::SLOT_EMPTY));

    // directed vector table
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7,
           vecs[i].imm, 1'b1, vecs[i].word, vecs[i].err, w);
    end
    drain();

    // stall: word held for 5 cycles with out_ready low
    out_ready = 1'b0;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 1'b1, 32'h0050_0093, 1'b0, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check32("stall_in_ready", 32'(in_ready), 32'd0);
      check32("stall_out_valid", 32'(out_valid), 32'd1);
      check32("stall_out_instr", out_instr, 32'h0050_0093);
      check32("stall_out_addr", out_addr, BASE + 32'(m_idx * 4));
      check32("stall_out_err", 32'(out_err), 32'd0);
      check32("stall_state", 32'(dbg_state), 32'(imm_encoder_pkg::SLOT_FULL));
      tick();
    end
    out_ready = 1'b1;
    drain();

    // clear, then DEPTH+1 back-to-back words: address wraps to BASE
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check32("clear_err_cnt", 32'(err_cnt), 32'd0);
    check32("clear_addr", out_addr, BASE);
    total = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      send(7'h13, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'd0, 3'd0, 7'h00,
           32'($urandom_range(0, 4095)) - 32'd2048, 1'b0, 32'h0, 1'b0, w);
      total += w;
    end
    check32("no_bubble_waits", 32'(total), 32'd0);
    drain();
    check32("wrap_addr", out_addr, BASE + 32'd4);

    // randomized traffic with random back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: r = $urandom;
        1: r = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: r = bnd[$urandom_range(0, 9)];
        default: r = $urandom & 32'hFFFF_F000;
      endcase
      send(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
           r, 1'b0, 32'h0, 1'b0, w);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;

    // err_cnt saturation
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 260; i++) begin
      send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 1'b0, 32'h0, 1'b0, w);
    end
    drain();
    check32("sat_err_cnt", 32'(err_cnt), 32'd255);

    // async reset while a word is held
    out_ready = 1'b0;
    send(7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'h00, 32'd9, 1'b0, 32'h0, 1'b0, w);
    #2;
    rst_n = 1'b0;
    #1;
    check32("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check32("mid_rst_addr", out_addr, BASE);
    check32("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    check32("mid_rst_instr", out_instr, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check32("post_rst_no_output", 32'(out_valid), 32'd0);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 1'b1, 32'h0050_0093, 1'b0, w);
    drain();

    // clear resets the error count
    for (int i = 0; i < 3; i++) begin
      send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd1, 1'b0, 32'h0, 1'b0, w);
    end
    drain();
    check32("pre_clear_err_cnt", 32'(err_cnt), 32'd3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check32("post_clear_err_cnt", 32'(err_cnt), 32'd0);
    check32("post_clear_addr", out_addr, BASE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
